exe_mem_req_ctrl: RTL

//  EX-stage data-memory request controller. Takes load/store ops from EX, checks alignment and issues

---
 rtl/exe_mem_req_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/exe_mem_req_ctrl.sv
// exe_mem_req_ctrl
//   EX-stage data-memory request controller. Accepts load/store ops from EX,
//   checks alignment, issues SRAM-like bus requests (req/addr_ok, data_ok)
//   and tracks up to MAX_OUTST accepted-but-unanswered accesses. Load data
//   goes back to MEM already lane-selected and sign/zero-extended. A flush
//   turns every in-flight access into a silent discard, so bus/FIFO ordering
//   stays in step with the memory side.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   EX op handshake (ready = issued or retired as misaligned)
//   in_we/in_size/in_signed/in_addr/in_wdata/in_meta   op description
//   blk, flush          suppress new requests / cancel in-flight accesses
//   ale                 current op is misaligned or has an illegal size
//   req/wr/size/addr/wstrb/wdata   bus request channel
//   addr_ok/data_ok/rdata          bus handshake and read data
//   resp_valid/resp_data/resp_meta/resp_store   completion to MEM
//   outst_cnt           number of outstanding accesses
module exe_mem_req_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int META_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_we,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [META_W-1:0]   in_meta,
  input  logic                blk,
  input  logic                flush,
  output logic                ale,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [META_W-1:0]   resp_meta,
  output logic                resp_store,
  output logic [3:0]          outst_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Byte-lane extraction already done by the caller; keep the low 8<<sz bits
  // and fill the rest with the sign bit (signed) or zeros.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0]        sz,
                                                    input logic              sgn);
    int                nbits;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] msb_sh;
    logic              fill;
    nbits = 8 << sz;
    if (nbits >= DATA_W) return raw;
    keep   = (DATA_W'(1) << nbits) - DATA_W'(1);
    msb_sh = raw >> (nbits - 1);
    fill   = sgn & msb_sh[0];
    return (raw & keep) | (fill ? ~keep : '0);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [3:0]       outst_cnt_q, outst_cnt_d;
  logic [3:0]       discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  // Per-request metadata, written at addr_ok and read at data_ok.
  logic [META_W-1:0] meta_q [MAX_OUTST];
  logic [1:0]        size_q [MAX_OUTST];
  logic              sgn_q  [MAX_OUTST];
  logic [LANE_W-1:0] lane_q [MAX_OUTST];
  logic              we_q   [MAX_OUTST];

  logic              misalign;
  logic              not_full;
  logic              push, pop;
  logic [LANE_W-1:0] lane_in;
  logic [STRB_W-1:0] size_mask;
  logic [DATA_W-1:0] raw_sel;

  // ---- request side (combinational on the EX op) ----
  always_comb begin
    misalign = 1'b0;
    case (in_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_addr[0];
      2'b10:   misalign = |in_addr[1:0];
      default: misalign = (DATA_W == 32) || (|in_addr[2:0]);
    endcase
  end

  assign not_full = outst_cnt_q < 4'(MAX_OUTST);
  assign ale      = in_valid & misalign;
  assign req      = ~reset & in_valid & ~misalign & ~blk & ~flush & not_full;
  assign push     = req & addr_ok;
  // A misaligned op is consumed without touching the bus so EX can raise ALE.
  assign in_ready = push | (~reset & in_valid & misalign & ~flush);
  // A stray data_ok with nothing outstanding is dropped.
  assign pop      = ~reset & data_ok & (outst_cnt_q != 4'd0);

  assign wr      = in_we;
  assign size    = in_size;
  assign addr    = in_addr;
  assign lane_in = in_addr[LANE_W-1:0];

  always_comb begin
    size_mask = '1;
    wdata     = in_wdata;
    case (in_size)
      2'b00: begin
        size_mask = STRB_W'(1);
        wdata     = {STRB_W{in_wdata[7:0]}};
      end
      2'b01: begin
        size_mask = STRB_W'(3);
        wdata     = {(STRB_W/2){in_wdata[15:0]}};
      end
      2'b10: begin
        size_mask = STRB_W'(15);
        wdata     = {(DATA_W/32){in_wdata[31:0]}};
      end
      default: begin
        size_mask = '1;
        wdata     = in_wdata;
      end
    endcase
  end

  assign wstrb = in_we ? (size_mask << lane_in) : '0;

  // ---- response side (combinational on data_ok, FIFO head) ----
  assign raw_sel    = rdata >> {lane_q[rd_ptr_q], 3'b000};
  assign resp_valid = pop & (discard_q == 4'd0);
  assign resp_meta  = meta_q[rd_ptr_q];
  assign resp_store = we_q[rd_ptr_q];
  assign resp_data  = we_q[rd_ptr_q] ? '0
                                     : load_extend(raw_sel, size_q[rd_ptr_q], sgn_q[rd_ptr_q]);
  assign outst_cnt  = outst_cnt_q;

  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (push && !pop)      outst_cnt_d = outst_cnt_q + 4'd1;
    else if (!push && pop) outst_cnt_d = outst_cnt_q - 4'd1;

    // Everything still in flight after this edge belongs to the flushed
    // stream; those completions are swallowed before anything newer.
    discard_d = discard_q;
    if (flush)                        discard_d = outst_cnt_q - {3'b000, pop};
    else if (pop && discard_q != 4'd0) discard_d = discard_q - 4'd1;
  end

  // ---- state update at the clock edge ----
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt_q <= 4'd0;
      discard_q   <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      outst_cnt_q <= outst_cnt_d;
      discard_q   <= discard_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      meta_q[wr_ptr_q] <= in_meta;
      size_q[wr_ptr_q] <= in_size;
      sgn_q[wr_ptr_q]  <= in_signed;
      lane_q[wr_ptr_q] <= lane_in;
      we_q[wr_ptr_q]   <= in_we;
    end
  end

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
                                       data_ok |-> (outst_cnt_q != 4'd0));

endmodule
